accel_spi_slave_model: RTL and testbench
========================================

Name: accel_spi_slave_model

Overview:
- Parametrised, synthesizable SPI accelerometer emulator (ADXL362-style command protocol) that replaces hand-toggled miso stimulus in Scary_maze_top benches and on-board loopback tests.
- Oversamples ss/sclk/mosi in the system clock domain and decodes write/read commands into a register file.
- Serves NUM_AXES live sample channels and a fixed device ID, with address auto-increment.

Parameters:
- DATA_W, 8, register and sample width in bits; equals SPI byte length.
- ADDR_W, 6, register address width.
- REG_DEPTH, 64, number of registers; must be ≤ 2**ADDR_W.
- NUM_AXES, 3, number of sample channels.
- SAMPLE_BASE, 8, address of axis 0; axis k sits at SAMPLE_BASE+k.
- DEVID, 8'hAD, read-only value at address 0.
- CMD_WR, 8'h0A, write command code.
- CMD_RD, 8'h0B, read command code.

Ports:
- clk  in  1  system clock; must be ≥ 8× the sclk frequency.
- in_reset  in  1  synchronous, active-high reset.
- ss  in  1  SPI slave select, active low.
- sclk  in  1  SPI clock; mode 0 (CPOL=0, CPHA=0).
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first; 0 when not driving.
- axis_data  in  NUM_AXES*DATA_W  live samples; axis k occupies bits [k*DATA_W +: DATA_W].
- axis_valid  in  1  one-cycle pulse; latch axis_data into the live sample registers.
- wr_strobe  out  1  one-cycle pulse on each completed write to a writable register.
- wr_addr  out  ADDR_W  address of the last write.
- wr_data  out  DATA_W  data of the last write.
- busy  out  1  high while ss is synchronised low.

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high on in_reset. All ss/sclk/mosi inputs pass through 2-flop synchronisers. sclk edges are detected from the synchronised value, so the internal view lags the pins by 3 clk.
- Reset values:
  - miso=0, wr_strobe=0, wr_addr=0, wr_data=0, busy=0.
  - FSM=IDLE; bit counter=0.
  - Scratch registers=0; live samples=0; snapshot=0.
- FSM states: IDLE, CMD, ADDR, DATA, DISCARD.
  - IDLE → CMD on synchronised ss falling edge; bit counter cleared.
  - Each rising sclk shifts mosi into the shift register (MSB first). The bit counter wraps after DATA_W bits and raises an internal byte_done for one cycle.
  - CMD, byte_done: CMD_WR or CMD_RD → ADDR, mode latched; any other code → DISCARD.
  - ADDR, byte_done: pointer := byte[ADDR_W-1:0] → DATA. In read mode, copy all live samples into the snapshot in this same cycle, so multi-byte reads are coherent.
  - DATA, write mode, byte_done:
    - Address 0 or in [SAMPLE_BASE, SAMPLE_BASE+NUM_AXES-1] → ignored, no strobe.
    - Pointer ≥ REG_DEPTH → ignored, no strobe.
    - Otherwise store the byte and pulse wr_strobe with wr_addr/wr_data.
    - Pointer then increments.
  - DATA, read mode:
    - The output byte is loaded at the ADDR→DATA transition and after each byte_done.
    - Source: DEVID at addr 0, snapshot for sample addresses, 0 for pointer ≥ REG_DEPTH, otherwise the scratch register.
    - miso presents the MSB immediately after load, then shifts on each falling sclk.
    - Pointer increments after each byte.
  - Pointer wraps from REG_DEPTH-1 to 0.
  - DISCARD: ignore everything; miso=0.
  - Any state, synchronised ss rising → IDLE. A partial byte is discarded and never written. miso=0; busy=0 the next cycle.
- axis_valid updates the live sample registers at any time. A read already in DATA keeps returning its snapshot.
- in_reset mid-transaction forces IDLE at once. The remaining SPI bits are ignored until the next ss falling edge.
- miso outside the DATA/read state: 0.

Decomposition:
- Shared package accel_spi_pkg: CMD_WR/CMD_RD defaults, DEVID default, SAMPLE_BASE default, FSM state encoding.
- One natural sub-module, spi_sync_edge: 2-flop synchroniser plus rise/fall detect, instantiated for ss and sclk.

Test Plan:
- Reset, then read: ss low, send 0x0B, 0x00, 1 dummy byte → miso returns 0xAD; busy=1 during the transfer, 0 after ss high.
- Write: send 0x0A, 0x20, 0x5A, 0x3C → wr_strobe pulses twice, with (0x20,0x5A) and then (0x21,0x3C). A following read from 0x20 returns 0x5A, 0x3C.
- Coherent samples: axis_data=0x030201, pulse axis_valid, then burst-read from 0x08. Mid-burst, set axis_data=0xFFFFFF with axis_valid → bytes read are 0x01, 0x02, 0x03.
- Wrap and read-only: write 0x0A, 0x3F, 0x11, 0x22 → strobes at 0x3F (data 0x11), then pointer wraps to 0x00. That write is ignored, no strobe; DEVID still reads 0xAD.
- Abort: ss high after 4 bits of a write data byte → no wr_strobe, target register unchanged. An invalid command 0x55 → miso stays 0 for the whole transfer.
- in_reset asserted mid-read → miso=0 the next cycle. The next well-formed transaction after ss toggles high then low works correctly.

Source files
------------

// File: rtl/accel_spi_pkg.sv
// Shared defaults and FSM encoding for the SPI accelerometer emulator.
package accel_spi_pkg;

   localparam logic [7:0] DEF_CMD_WR      = 8'h0A;
   localparam logic [7:0] DEF_CMD_RD      = 8'h0B;
   localparam logic [7:0] DEF_DEVID       = 8'hAD;
   localparam int         DEF_SAMPLE_BASE = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_DISCARD
   } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser followed by a history flop for rise/fall detection.
// All flops reset low, so a line that is already low coming out of reset
// never produces a fall; a real high phase has to be observed first.
module spi_sync_edge (
   input  logic clk,
   input  logic in_reset,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   // next values: plain shift through the synchroniser chain
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // synchroniser and history registers
   always_ff @(posedge clk) begin
      if (in_reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/accel_spi_slave_model.sv
// SPI accelerometer emulator: oversampled mode-0 slave decoding write/read
// commands into a scratch register file, live sample channels and a device ID.
module accel_spi_slave_model
   import accel_spi_pkg::*;
#(
   parameter int                DATA_W      = 8,
   parameter int                ADDR_W      = 6,
   parameter int                REG_DEPTH   = 64,
   parameter int                NUM_AXES    = 3,
   parameter int                SAMPLE_BASE = DEF_SAMPLE_BASE,
   parameter logic [DATA_W-1:0] DEVID       = DEF_DEVID,
   parameter logic [DATA_W-1:0] CMD_WR      = DEF_CMD_WR,
   parameter logic [DATA_W-1:0] CMD_RD      = DEF_CMD_RD
) (
   input  logic                       clk,
   input  logic                       in_reset,
   input  logic                       ss,
   input  logic                       sclk,
   input  logic                       mosi,
   output logic                       miso,
   input  logic [NUM_AXES*DATA_W-1:0] axis_data,
   input  logic                       axis_valid,
   output logic                       wr_strobe,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [DATA_W-1:0]          wr_data,
   output logic                       busy
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam int RD_W  = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
   localparam int AX_W  = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   spi_state_e              state_q, state_d;
   logic                    rd_q, rd_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DATA_W-2:0]       shift_q, shift_d;
   logic [ADDR_W-1:0]       ptr_q, ptr_d;
   logic [DATA_W-1:0]       tx_q, tx_d;
   logic [DATA_W-1:0]       scratch_q [REG_DEPTH];
   logic [DATA_W-1:0]       scratch_d [REG_DEPTH];
   logic [DATA_W-1:0]       live_q [NUM_AXES];
   logic [DATA_W-1:0]       live_d [NUM_AXES];
   logic [DATA_W-1:0]       snap_q [NUM_AXES];
   logic [DATA_W-1:0]       snap_d [NUM_AXES];
   logic                    wr_strobe_q, wr_strobe_d;
   logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]       wr_data_q, wr_data_d;
   logic                    busy_q, busy_d;
   logic                    mosi_meta_q, mosi_meta_d;
   logic                    mosi_sync_q, mosi_sync_d;

   logic                    ss_rise, ss_fall, sclk_rise, sclk_fall;
   logic                    byte_done, wr_ok;
   logic [DATA_W-1:0]       rx_byte, rd_val;
   logic [ADDR_W-1:0]       ptr_inc, ld_ptr;
   int                      ld_idx, wr_idx;

   spi_sync_edge u_ss_sync (
      .clk(clk), .in_reset(in_reset), .d(ss), .rise(ss_rise), .fall(ss_fall)
   );

   spi_sync_edge u_sclk_sync (
      .clk(clk), .in_reset(in_reset), .d(sclk), .rise(sclk_rise), .fall(sclk_fall)
   );

   // pointer decode: next pointer, read source for the byte about to load, write permission
   always_comb begin
      ptr_inc = (int'(ptr_q) == REG_DEPTH - 1) ? '0 : ptr_q + ADDR_W'(1);
      ld_ptr  = (state_q == ST_ADDR) ? rx_byte[ADDR_W-1:0] : ptr_inc;
      ld_idx  = int'(ld_ptr);
      rd_val  = '0;
      if (ld_idx == 0) begin
         rd_val = DEVID;
      end else if (ld_idx >= SAMPLE_BASE && ld_idx < SAMPLE_BASE + NUM_AXES) begin
         // at the address byte the snapshot is being taken this cycle, so read live
         rd_val = (state_q == ST_ADDR) ? live_q[AX_W'(ld_idx - SAMPLE_BASE)]
                                       : snap_q[AX_W'(ld_idx - SAMPLE_BASE)];
      end else if (ld_idx < REG_DEPTH) begin
         rd_val = scratch_q[RD_W'(ld_ptr)];
      end
      wr_idx = int'(ptr_q);
      wr_ok  = (wr_idx != 0) && (wr_idx < REG_DEPTH) &&
               !(wr_idx >= SAMPLE_BASE && wr_idx < SAMPLE_BASE + NUM_AXES);
   end

   // protocol FSM, bit/byte assembly, register file and output shifting
   always_comb begin
      state_d     = state_q;
      rd_d        = rd_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      tx_d        = tx_q;
      scratch_d   = scratch_q;
      live_d      = live_q;
      snap_d      = snap_q;
      wr_strobe_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      mosi_meta_d = mosi;
      mosi_sync_d = mosi_meta_q;
      byte_done   = 1'b0;
      rx_byte     = {shift_q, mosi_sync_q};

      if (axis_valid) begin
         for (int k = 0; k < NUM_AXES; k++) live_d[k] = axis_data[k*DATA_W +: DATA_W];
      end

      if (ss_rise) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (ss_fall) begin
         state_d = ST_CMD;
         cnt_d   = '0;
      end else if (state_q == ST_CMD || state_q == ST_ADDR || state_q == ST_DATA) begin
         if (sclk_rise) begin
            shift_d = rx_byte[DATA_W-2:0];
            if (cnt_q == LAST_BIT) begin
               cnt_d     = '0;
               byte_done = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         // the falling edge right after a load keeps the MSB for the next rising edge
         if (sclk_fall && cnt_q != '0) tx_d = {tx_q[DATA_W-2:0], 1'b0};
         if (byte_done) begin
            case (state_q)
               ST_CMD: begin
                  if (rx_byte == CMD_WR) begin
                     state_d = ST_ADDR;
                     rd_d    = 1'b0;
                  end else if (rx_byte == CMD_RD) begin
                     state_d = ST_ADDR;
                     rd_d    = 1'b1;
                  end else begin
                     state_d = ST_DISCARD;
                  end
               end
               ST_ADDR: begin
                  ptr_d   = ld_ptr;
                  state_d = ST_DATA;
                  if (rd_q) begin
                     snap_d = live_q;
                     tx_d   = rd_val;
                  end
               end
               ST_DATA: begin
                  if (!rd_q && wr_ok) begin
                     scratch_d[RD_W'(ptr_q)] = rx_byte;
                     wr_strobe_d = 1'b1;
                     wr_addr_d   = ptr_q;
                     wr_data_d   = rx_byte;
                  end
                  ptr_d = ptr_inc;
                  if (rd_q) tx_d = rd_val;
               end
               default: ;
            endcase
         end
      end

      busy_d = (state_d != ST_IDLE);
   end

   // state registers
   always_ff @(posedge clk) begin
      if (in_reset) begin
         state_q     <= ST_IDLE;
         rd_q        <= 1'b0;
         cnt_q       <= '0;
         shift_q     <= '0;
         ptr_q       <= '0;
         tx_q        <= '0;
         scratch_q   <= '{default: '0};
         live_q      <= '{default: '0};
         snap_q      <= '{default: '0};
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         busy_q      <= 1'b0;
         mosi_meta_q <= 1'b0;
         mosi_sync_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         tx_q        <= tx_d;
         scratch_q   <= scratch_d;
         live_q      <= live_d;
         snap_q      <= snap_d;
         wr_strobe_q <= wr_strobe_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
         mosi_meta_q <= mosi_meta_d;
         mosi_sync_q <= mosi_sync_d;
      end
   end

   assign miso      = (state_q == ST_DATA && rd_q) ? tx_q[DATA_W-1] : 1'b0;
   assign wr_strobe = wr_strobe_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_accel_spi_slave_model.sv
// Bench for accel_spi_slave_model: SPI master tasks, a register-level model
// of the device, and a per-cycle checker for miso quietness and write strobes.
module tb_accel_spi_slave_model;

   localparam int HALF = 6;   // clk cycles per sclk half period

   logic        clk = 1'b0;
   logic        in_reset, ss, sclk, mosi, axis_valid;
   logic [23:0] axis_data;
   logic        miso, wr_strobe, busy;
   logic [5:0]  wr_addr;
   logic [7:0]  wr_data;

   always #5 clk = ~clk;

   accel_spi_slave_model dut (
      .clk(clk), .in_reset(in_reset), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
      .axis_data(axis_data), .axis_valid(axis_valid), .wr_strobe(wr_strobe),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
   );

   int          n_checks = 0;
   int          n_err    = 0;
   logic        chk_en    = 1'b0;
   logic        may_drive = 1'b0;
   logic [7:0]  m_reg  [64];
   logic [7:0]  m_live [3];
   logic [13:0] exp_wr_q [$];
   logic [13:0] e_wr;
   logic [7:0]  txb [16];
   logic [7:0]  rxb [16];
   logic [7:0]  exp_rd [16];
   logic [7:0]  junk;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // device view: what a read of address a returns (samples from the model's live values)
   function automatic logic [7:0] model_val(input int a);
      if (a == 0) return 8'hAD;
      if (a >= 8 && a <= 10) return m_live[a-8];
      return m_reg[a];
   endfunction

   function automatic logic writable(input int a);
      return (a != 0) && !(a >= 8 && a <= 10);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
      for (int k = 0; k < 3; k++) m_live[k] = 8'h00;
   endfunction

   // shift nb bits of b out MSB first; capture miso at each rising edge
   task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
      r = 8'h00;
      for (int i = 7; i >= 8 - nb; i--) begin
         mosi = b[i];
         repeat (HALF) @(negedge clk);
         r = {r[6:0], miso};
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic axis_pulse(input logic [23:0] v);
      @(negedge clk);
      axis_data  = v;
      axis_valid = 1'b1;
      @(negedge clk);
      axis_valid = 1'b0;
      for (int k = 0; k < 3; k++) m_live[k] = v[k*8 +: 8];
   endtask

   // full transaction of n bytes from txb, then optionally part bits of txb[n]
   task automatic xact(input int n, input int part);
      int   a;
      logic is_rd;
      is_rd = (txb[0] == 8'h0B) && (n > 2);
      if (n >= 2 && (txb[0] == 8'h0A || txb[0] == 8'h0B)) begin
         a = int'(txb[1][5:0]);
         for (int i = 2; i < n; i++) begin
            if (txb[0] == 8'h0A) begin
               if (writable(a)) begin
                  exp_wr_q.push_back({a[5:0], txb[i]});
                  m_reg[a] = txb[i];
               end
            end else begin
               exp_rd[i] = model_val(a);
            end
            a = (a + 1) % 64;
         end
      end
      may_drive = (txb[0] == 8'h0B);
      @(negedge clk);
      ss = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < n; i++) spi_bits(txb[i], 8, rxb[i]);
      if (part > 0) spi_bits(txb[n], part, junk);
      repeat (HALF) @(negedge clk);
      chk("busy_during", busy, 1);
      ss = 1'b1;
      repeat (8) @(negedge clk);
      chk("busy_after", busy, 0);
      chk("wr_missing", exp_wr_q.size(), 0);
      exp_wr_q.delete();
      may_drive = 1'b0;
      if (is_rd) for (int i = 2; i < n; i++) chk("rd_model", rxb[i], exp_rd[i]);
   endtask

   // per-cycle checker: miso quiet whenever no read can be driving, strobes match the model
   always @(negedge clk) begin
      if (chk_en) begin
         if (!may_drive) chk("miso_quiet", miso, 0);
         if (wr_strobe === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL wr_strobe_extra: got strobe addr %0h data %0h expected none", wr_addr, wr_data);
            end else begin
               e_wr = exp_wr_q.pop_front();
               chk("wr_addr", wr_addr, e_wr[13:8]);
               chk("wr_data", wr_data, e_wr[7:0]);
            end
         end
      end
   end

   initial begin
      int         kind, n, part;
      logic [7:0] c;

      in_reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
      axis_valid = 1'b0; axis_data = '0;
      model_reset();
      repeat (4) @(negedge clk);
      in_reset = 1'b0;
      chk("rst_miso", miso, 0);
      chk("rst_wr_strobe", wr_strobe, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      repeat (4) @(negedge clk);
      chk_en = 1'b1;

      // device ID read
      txb[0] = 8'h0B; txb[1] = 8'h00; txb[2] = 8'h00;
      xact(3, 0);
      chk("devid_lit", rxb[2], 8'hAD);

      // two-byte write with auto-increment, then read back
      txb[0] = 8'h0A; txb[1] = 8'h20; txb[2] = 8'h5A; txb[3] = 8'h3C;
      xact(4, 0);
      txb[0] = 8'h0B; txb[1] = 8'h20; txb[2] = 8'h00; txb[3] = 8'h00;
      xact(4, 0);
      chk("rdback0_lit", rxb[2], 8'h5A);
      chk("rdback1_lit", rxb[3], 8'h3C);

      // coherent sample burst with a live update mid-burst
      axis_pulse(24'h030201);
      txb[0] = 8'h0B; txb[1] = 8'h08; txb[2] = 8'h00; txb[3] = 8'h00; txb[4] = 8'h00;
      fork
         xact(5, 0);
         begin
            repeat (HALF + 32 * HALF + 24) @(negedge clk);
            axis_pulse(24'hFFFFFF);
         end
      join
      chk("snap0_lit", rxb[2], 8'h01);
      chk("snap1_lit", rxb[3], 8'h02);
      chk("snap2_lit", rxb[4], 8'h03);
      txb[0] = 8'h0B; txb[1] = 8'h08; txb[2] = 8'h00;
      xact(3, 0);
      chk("live_after_lit", rxb[2], 8'hFF);

      // pointer wrap into read-only address 0
      txb[0] = 8'h0A; txb[1] = 8'h3F; txb[2] = 8'h11; txb[3] = 8'h22;
      xact(4, 0);
      txb[0] = 8'h0B; txb[1] = 8'h3F; txb[2] = 8'h00; txb[3] = 8'h00;
      xact(4, 0);
      chk("wrap_3f_lit", rxb[2], 8'h11);
      chk("wrap_devid_lit", rxb[3], 8'hAD);

      // aborted write: four bits of a data byte, then ss high
      txb[0] = 8'h0A; txb[1] = 8'h30; txb[2] = 8'h99;
      xact(2, 4);
      txb[0] = 8'h0B; txb[1] = 8'h30; txb[2] = 8'h00;
      xact(3, 0);
      chk("abort_lit", rxb[2], 8'h00);

      // invalid command: miso must stay low throughout
      txb[0] = 8'h55; txb[1] = 8'h12; txb[2] = 8'h34; txb[3] = 8'hFF;
      xact(4, 0);
      chk("invalid_lit", rxb[1] | rxb[2] | rxb[3], 8'h00);

      // reset in the middle of a read
      may_drive = 1'b1;
      @(negedge clk);
      ss = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(8'h0B, 8, junk);
      spi_bits(8'h20, 8, junk);
      spi_bits(8'h00, 3, junk);
      @(negedge clk);
      in_reset = 1'b1;
      @(negedge clk);
      in_reset = 1'b0;
      chk("miso_after_rst", miso, 0);
      may_drive = 1'b0;
      model_reset();
      spi_bits(8'hA5, 5, junk);
      spi_bits(8'h0A, 8, junk);
      repeat (HALF) @(negedge clk);
      ss = 1'b1;
      repeat (8) @(negedge clk);
      txb[0] = 8'h0A; txb[1] = 8'h20; txb[2] = 8'h77;
      xact(3, 0);
      txb[0] = 8'h0B; txb[1] = 8'h20; txb[2] = 8'h00; txb[3] = 8'h00;
      xact(4, 0);
      chk("post_rst_wr_lit", rxb[2], 8'h77);
      chk("post_rst_clr_lit", rxb[3], 8'h00);

      // randomized transactions against the model
      for (int t = 0; t < 30; t++) begin
         if ($urandom_range(0, 3) == 0) axis_pulse($urandom);
         kind = $urandom_range(0, 9);
         if (kind < 5) begin
            c = 8'h0A;
         end else if (kind < 9) begin
            c = 8'h0B;
         end else begin
            c = 8'($urandom);
            while (c == 8'h0A || c == 8'h0B) c = 8'($urandom);
         end
         n = 2 + $urandom_range(1, 4);
         part = (kind == 2) ? $urandom_range(1, 7) : 0;
         txb[0] = c;
         for (int i = 1; i <= n; i++) txb[i] = 8'($urandom);
         xact(n, part);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
